pose_scan_ctrl: RTL
===================

// Module: pose_scan_ctrl
// PURPOSE
// - Sequences pose lookups for one PRM edge check. Walks poseIndex from startIdx to endIdx (inclusive, 11-bit wrap)
//   into the pose encoder, waits its read latency, hands each pose to the grid collision checker (valid/ready),
//   and collects the hit flag. Stops at the first hit. Sits between the edge scheduler and pose encoder + checker.
// PARAMETERS
// - RD_LAT   2   pose-encoder cycles from poseIndex change to grid/XLoc/YLoc/ZLoc stable (1..15)
// - IDX_W    11  pose index width (fixed by encoder; wrap modulo 2**IDX_W)
// PORTS
// - CLK        in   1      clock, all logic on rising edge
// - RST_n      in   1      asynchronous active-low reset
// - start      in   1      1-cycle request; sampled only in IDLE
// - abort      in   1      cancel scan; overrides all other inputs
// - startIdx   in   11     first pose, captured on accepted start
// - endIdx     in   11     last pose (inclusive), captured on accepted start
// - poseIndex  out  11     address to pose encoder
// - chkValid   out  1      pose data at encoder output is valid for checker
// - chkReady   in   1      checker accepts current pose (transfer = chkValid & chkReady)
// - resValid   in   1      checker result strobe, 1 cycle
// - resHit     in   1      collision flag, qualified by resValid
// - busy       out  1      high from accepted start until done/abort
// - done       out  1      1-cycle pulse: scan finished (hit or all clear)
// - collide    out  1      result of last completed scan, held until next accepted start
// - hitIdx     out  11     pose index of first hit; holds last value when no hit
// BEHAVIOUR
// - Reset: state IDLE; poseIndex=0, chkValid=0, busy=0, done=0, collide=0, hitIdx=0, internal counters 0.
// - FSM IDLE->ISSUE->WAIT->OFFER->RESULT->{ISSUE|FIN}->IDLE:
//   IDLE: start=1 (abort=0) captures idx=startIdx, last=endIdx, clears collide; next ISSUE; busy=1 next cycle.
//   ISSUE: poseIndex=idx registered; load latency counter=RD_LAT; ->WAIT.
//   WAIT: decrement counter each cycle; at 1 ->OFFER. Total ISSUE..first OFFER cycle = RD_LAT+1 cycles.
//   OFFER: chkValid=1, held with poseIndex stable until chkReady=1; on transfer chkValid drops next cycle ->RESULT.
//   RESULT: wait resValid. resHit=1: collide=1, hitIdx=idx ->FIN. resHit=0: idx==last ->FIN,
//     else idx=idx+1 (mod 2048) ->ISSUE.
//   FIN: done=1 for exactly one cycle, busy=0 same cycle as done deasserts... busy falls with done's cycle end;
//     i.e. busy=0 and done=1 both registered in FIN; ->IDLE.
// - Pose count = ((endIdx - startIdx) mod 2048) + 1; startIdx==endIdx checks exactly one pose;
//   endIdx<startIdx wraps 2047->0. A full 2048-pose scan is endIdx = startIdx-1.
// - resValid/resHit outside RESULT ignored. chkReady outside OFFER ignored.
// - start while busy ignored (no queueing); start in same cycle as FIN-return is ignored, accepted next cycle in IDLE.
// - abort (any state): next cycle IDLE, chkValid=0, busy=0, no done pulse, collide/hitIdx keep pre-abort values
//   (collide already cleared if start was accepted). abort and start same cycle in IDLE: abort wins.
// - Async reset mid-scan: immediate return to reset values; no done.
// - poseIndex holds its last value in IDLE (encoder need not be gated).
// CONFIGURATION
// - POSE_SCAN_STAT_EN defined: extra output port chkCnt[11:0] = number of poses whose result was received in the
//   current/last scan; cleared on accepted start, +1 per RESULT with resValid, held after done/abort, 0 on reset.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - RD_LAT=2, start idx 5..8, checker ready always, all resHit=0 -> poseIndex 5,6,7,8; 4 transfers; done, collide=0.
// - start 10..20, resHit=1 on idx 13 -> scan stops, no chkValid for 14; done, collide=1, hitIdx=13 (chkCnt=4).
// - start 2046..1 -> poseIndex 2046,2047,0,1; done after 4 results; start 7..7 -> exactly one pose checked.
// - chkReady low 5 cycles in OFFER -> chkValid and poseIndex held stable; proceeds on first ready cycle.
// - abort asserted in WAIT of 3rd pose of 0..9 -> IDLE next cycle, busy=0, no done, chkValid never rises again.
// - start pulsed while busy, and RST_n low mid-RESULT -> start ignored; reset forces all outputs to reset values.

Source files
------------

// File: rtl/pose_scan_ctrl.sv
// pose_scan_ctrl: sequences pose-encoder lookups for one PRM edge check.
// Walks an 11-bit pose index from startIdx to endIdx (inclusive, wrapping),
// waits the encoder read latency, offers each pose to the collision checker
// and stops at the first reported hit.
// Optional feature macro: POSE_SCAN_STAT_EN adds the chkCnt result counter.
module pose_scan_ctrl #(
   parameter int RD_LAT = 2,   // encoder latency, 1..15
   parameter int IDX_W  = 11
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W-1:0] startIdx,
   input  logic [IDX_W-1:0] endIdx,
   output logic [IDX_W-1:0] poseIndex,
   output logic             chkValid,
   input  logic             chkReady,
   input  logic             resValid,
   input  logic             resHit,
   output logic             busy,
   output logic             done,
   output logic             collide,
   output logic [IDX_W-1:0] hitIdx
`ifdef POSE_SCAN_STAT_EN
   ,
   output logic [11:0]      chkCnt
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      OFFER  = 3'd3,
      RESULT = 3'd4,
      FIN    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;       // pose currently being processed
   logic [IDX_W-1:0] last_q, last_d;     // final pose of the scan (inclusive)
   logic [IDX_W-1:0] pose_q, pose_d;     // registered encoder address
   logic [3:0]       lat_q, lat_d;       // remaining encoder latency cycles
   logic             collide_q, collide_d;
   logic [IDX_W-1:0] hit_q, hit_d;
`ifdef POSE_SCAN_STAT_EN
   logic [11:0]      cnt_q, cnt_d;
`endif

   // State register and datapath registers; async reset to idle values
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         pose_q    <= '0;
         lat_q     <= '0;
         collide_q <= 1'b0;
         hit_q     <= '0;
`ifdef POSE_SCAN_STAT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         pose_q    <= pose_d;
         lat_q     <= lat_d;
         collide_q <= collide_d;
         hit_q     <= hit_d;
`ifdef POSE_SCAN_STAT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Next-state and datapath update; abort beats every other input
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      pose_d    = pose_q;
      lat_d     = lat_q;
      collide_d = collide_q;
      hit_d     = hit_q;
`ifdef POSE_SCAN_STAT_EN
      cnt_d     = cnt_q;
`endif
      if (abort) begin
         // result registers keep their pre-abort values
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_d     = startIdx;
                  last_d    = endIdx;
                  collide_d = 1'b0;
`ifdef POSE_SCAN_STAT_EN
                  cnt_d     = '0;
`endif
                  state_d   = ISSUE;
               end
            end
            ISSUE: begin
               pose_d  = idx_q;
               lat_d   = 4'(RD_LAT);
               state_d = WAIT;
            end
            WAIT: begin
               // counter at 1 means encoder data is stable next cycle
               if (lat_q <= 4'd1) state_d = OFFER;
               else               lat_d   = lat_q - 4'd1;
            end
            OFFER: begin
               if (chkReady) state_d = RESULT;
            end
            RESULT: begin
               if (resValid) begin
`ifdef POSE_SCAN_STAT_EN
                  cnt_d = cnt_q + 12'd1;
`endif
                  if (resHit) begin
                     collide_d = 1'b1;
                     hit_d     = idx_q;
                     state_d   = FIN;
                  end else if (idx_q == last_q) begin
                     state_d = FIN;
                  end else begin
                     idx_d   = idx_q + 1'b1;  // natural wrap modulo 2**IDX_W
                     state_d = ISSUE;
                  end
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state
   assign poseIndex = pose_q;
   assign chkValid  = (state_q == OFFER);
   assign busy      = (state_q == ISSUE) || (state_q == WAIT) ||
                      (state_q == OFFER) || (state_q == RESULT);
   assign done      = (state_q == FIN);
   assign collide   = collide_q;
   assign hitIdx    = hit_q;
`ifdef POSE_SCAN_STAT_EN
   assign chkCnt    = cnt_q;
`endif

endmodule
